// File: rtl/apb_uart_pkg.sv
// -----------------------------------------------------------------------------
// apb_uart_pkg
// Shared definitions for the UART APB register block:
//   - register byte offsets
//   - CTRL and STATUS bit positions
//   - APB slave FSM state encoding
// -----------------------------------------------------------------------------
package apb_uart_pkg;

  localparam int BYTE_W = 8;

  // Register byte offsets (word aligned).
  localparam int unsigned OFF_CTRL   = 'h00;
  localparam int unsigned OFF_STATUS = 'h04;
  localparam int unsigned OFF_TXDATA = 'h08;
  localparam int unsigned OFF_RXDATA = 'h0C;
  localparam int unsigned OFF_BAUDIV = 'h10;

  // CTRL bit positions.
  localparam int CTRL_TX_EN     = 0;
  localparam int CTRL_RX_EN     = 1;
  localparam int CTRL_TX_IRQ_EN = 2;
  localparam int CTRL_RX_IRQ_EN = 3;

  // STATUS bit positions.
  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_RX_FULL      = 2;
  localparam int ST_RX_OVERRUN   = 3;
  localparam int ST_TX_LEVEL_LSB = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

endpackage

// File: rtl/apb_uart_txfifo.sv
// -----------------------------------------------------------------------------
// apb_uart_txfifo
// Synchronous DEPTH x 8 transmit FIFO. A push while full is dropped; fullness
// is judged on the registered level, so a pop in the same cycle does not make
// room for a push.
//
// Ports:
//   PCLK, PRESETn  clock, asynchronous active-low reset
//   i_push         push request, i_push_data is the byte
//   i_pop          pop request (ignored when empty)
//   o_head         byte at the head, 0 when empty
//   o_full/o_empty occupancy flags
//   o_level        number of bytes held (0..DEPTH)
// -----------------------------------------------------------------------------
module apb_uart_txfifo
  import apb_uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty,
  output logic [LVL_W-1:0]  o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]  r_level;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the level/pointers define which
  // entries are valid and the head is masked to 0 while empty.
  always_ff @(posedge PCLK) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/apb_uart_csr.sv
// -----------------------------------------------------------------------------
// apb_uart_csr
// APB3 register block for the UART. Holds CTRL and BAUDIV, buffers transmit
// bytes in a FIFO, latches received bytes with overrun detection and drives
// the level interrupt.
//
// Ports:
//   PCLK, PRESETn          APB clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE    APB controls; PADDR byte address; PWDATA write data
//   PRDATA                 read data, nonzero only in a completing good read
//   PREADY, PSLVERR        transfer completion and error response
//   tx_valid/tx_data       FIFO head towards the TX engine; tx_ready pops it
//   rx_valid/rx_data       one-cycle strobe of a received byte
//   ctrl_o, baud_div_o     register contents for the UART engines
//   irq                    level interrupt
//
// Register map: 0x00 CTRL, 0x04 STATUS (bit 3 W1C), 0x08 TXDATA (WO),
//               0x0C RXDATA (RO), 0x10 BAUDIV.
// -----------------------------------------------------------------------------
module apb_uart_csr
  import apb_uart_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,  // at least 16
  parameter int WAIT_STATES = 0,   // 0..7
  parameter int TX_DEPTH    = 8    // power of two, 2..64
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic [3:0]            ctrl_o,
  output logic [15:0]           baud_div_o,
  output logic                  irq
);

  localparam int LVL_W = $clog2(TX_DEPTH) + 1;

  // ---------------------------------------------------------------------------
  // APB slave FSM
  // ---------------------------------------------------------------------------
  apb_state_e r_state;
  apb_state_e w_state_nxt;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          w_state_nxt = ACCESS;
          w_cnt_nxt   = 3'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          // Master abandoned the transfer: nothing is committed.
          w_state_nxt = IDLE;
        end else if (r_cnt != 3'd0) begin
          w_cnt_nxt = r_cnt - 3'd1;
        end else if (PENABLE) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  logic w_complete;

  assign PREADY     = (r_state == ACCESS) && (r_cnt == 3'd0);
  assign w_complete = PREADY & PSEL & PENABLE;

  // ---------------------------------------------------------------------------
  // Address decode and error response
  // ---------------------------------------------------------------------------
  logic w_sel_ctrl, w_sel_status, w_sel_txdata, w_sel_rxdata, w_sel_baud;
  logic w_misaligned, w_mapped, w_err;
  logic w_tx_full, w_tx_empty;

  assign w_sel_ctrl   = (PADDR == ADDR_WIDTH'(OFF_CTRL));
  assign w_sel_status = (PADDR == ADDR_WIDTH'(OFF_STATUS));
  assign w_sel_txdata = (PADDR == ADDR_WIDTH'(OFF_TXDATA));
  assign w_sel_rxdata = (PADDR == ADDR_WIDTH'(OFF_RXDATA));
  assign w_sel_baud   = (PADDR == ADDR_WIDTH'(OFF_BAUDIV));
  assign w_misaligned = |PADDR[1:0];
  assign w_mapped     = w_sel_ctrl | w_sel_status | w_sel_txdata |
                        w_sel_rxdata | w_sel_baud;

  // Uses only registered FIFO state, so tx_ready never reaches PSLVERR.
  assign w_err = ~w_mapped | w_misaligned |
                 ( PWRITE & w_sel_rxdata) |
                 (~PWRITE & w_sel_txdata) |
                 ( PWRITE & w_sel_txdata & w_tx_full);

  logic w_wr_ok, w_rd_ok;

  assign w_wr_ok = w_complete & ~w_err &  PWRITE;
  assign w_rd_ok = w_complete & ~w_err & ~PWRITE;
  assign PSLVERR = w_complete & w_err;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [3:0]  r_ctrl;
  logic [15:0] r_baud;
  logic [7:0]  r_rx_data;
  logic        r_rx_full;
  logic        r_rx_overrun;

  logic w_rx_in, w_rx_rd, w_ovr_set, w_ovr_clr;

  assign w_rx_in   = rx_valid & r_ctrl[CTRL_RX_EN];
  assign w_rx_rd   = w_rd_ok & w_sel_rxdata;
  // A same-cycle RXDATA read frees the holding register, so no overrun then.
  assign w_ovr_set = w_rx_in & r_rx_full & ~w_rx_rd;
  assign w_ovr_clr = w_wr_ok & w_sel_status & PWDATA[ST_RX_OVERRUN];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_ctrl       <= '0;
      r_baud       <= '0;
      r_rx_data    <= '0;
      r_rx_full    <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      if (w_wr_ok && w_sel_ctrl) r_ctrl <= PWDATA[3:0];
      if (w_wr_ok && w_sel_baud) r_baud <= PWDATA[15:0];

      if (w_rx_in && (!r_rx_full || w_rx_rd)) begin
        r_rx_data <= rx_data;
        r_rx_full <= 1'b1;
      end else if (w_rx_rd) begin
        r_rx_full <= 1'b0;
      end

      // A fresh overrun wins over a simultaneous W1C.
      if (w_ovr_set)      r_rx_overrun <= 1'b1;
      else if (w_ovr_clr) r_rx_overrun <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       w_tx_head;
  logic [LVL_W-1:0] w_tx_level;
  logic             w_tx_pop;

  assign w_tx_pop = tx_valid & tx_ready;

  apb_uart_txfifo #(
    .DEPTH (TX_DEPTH),
    .LVL_W (LVL_W)
  ) u_txfifo (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .i_push      (w_wr_ok & w_sel_txdata),
    .i_push_data (PWDATA[7:0]),
    .i_pop       (w_tx_pop),
    .o_head      (w_tx_head),
    .o_full      (w_tx_full),
    .o_empty     (w_tx_empty),
    .o_level     (w_tx_level)
  );

  // ---------------------------------------------------------------------------
  // Read mux and outputs
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    if (w_sel_ctrl) w_rdata[3:0] = r_ctrl;
    if (w_sel_status) begin
      w_rdata[ST_TX_FULL]                      = w_tx_full;
      w_rdata[ST_TX_EMPTY]                     = w_tx_empty;
      w_rdata[ST_RX_FULL]                      = r_rx_full;
      w_rdata[ST_RX_OVERRUN]                   = r_rx_overrun;
      w_rdata[ST_TX_LEVEL_LSB +: 8]            = 8'(w_tx_level);
    end
    if (w_sel_rxdata) w_rdata[7:0]  = r_rx_data;
    if (w_sel_baud)   w_rdata[15:0] = r_baud;
  end

  assign PRDATA = w_rd_ok ? w_rdata : '0;

  assign tx_valid   = ~w_tx_empty & r_ctrl[CTRL_TX_EN];
  assign tx_data    = w_tx_head;
  assign ctrl_o     = r_ctrl;
  assign baud_div_o = r_baud;
  assign irq        = (r_ctrl[CTRL_TX_IRQ_EN] & w_tx_empty) |
                      (r_ctrl[CTRL_RX_IRQ_EN] & r_rx_full)  |
                      r_rx_overrun;

  // Upper write-data bits are ignored by design.
  logic w_unused_pwdata;
  assign w_unused_pwdata = ^PWDATA;

endmodule

// File: tb/tb_apb_uart_csr.sv
// -----------------------------------------------------------------------------
// tb_apb_uart_csr
// Self-checking bench for apb_uart_csr. Main instance uses WAIT_STATES=2;
// a second instance with WAIT_STATES=3 exercises the aborted transfer.
// -----------------------------------------------------------------------------
module tb_apb_uart_csr;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  // Main instance (WAIT_STATES = 2)
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        tx_valid, tx_ready, rx_valid;
  logic [7:0]  tx_data, rx_data;
  logic [3:0]  ctrl_o;
  logic [15:0] baud_div_o;
  logic        irq;

  // Second instance (WAIT_STATES = 3)
  logic        b_psel, b_penable, b_pwrite;
  logic [11:0] b_paddr;
  logic [31:0] b_pwdata, b_prdata;
  logic        b_pready, b_pslverr;
  logic        b_tx_valid, b_tx_ready, b_rx_valid;
  logic [7:0]  b_tx_data, b_rx_data;
  logic [3:0]  b_ctrl_o;
  logic [15:0] b_baud_div_o;
  logic        b_irq;

  apb_uart_csr #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_STATES(2), .TX_DEPTH(8)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .ctrl_o(ctrl_o), .baud_div_o(baud_div_o),
    .irq(irq)
  );

  apb_uart_csr #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_STATES(3), .TX_DEPTH(8)) dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(b_psel), .PENABLE(b_penable), .PWRITE(b_pwrite),
    .PADDR(b_paddr), .PWDATA(b_pwdata), .PRDATA(b_prdata), .PREADY(b_pready),
    .PSLVERR(b_pslverr), .tx_valid(b_tx_valid), .tx_data(b_tx_data), .tx_ready(b_tx_ready),
    .rx_valid(b_rx_valid), .rx_data(b_rx_data), .ctrl_o(b_ctrl_o),
    .baud_div_o(b_baud_div_o), .irq(b_irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_apb(input bit u3, input logic s, input logic e, input logic w,
                         input logic [11:0] a, input logic [31:0] d);
    if (u3) begin
      b_psel = s; b_penable = e; b_pwrite = w; b_paddr = a; b_pwdata = d;
    end else begin
      psel = s; penable = e; pwrite = w; paddr = a; pwdata = d;
    end
  endtask

  // One APB transfer; starts and ends just after a rising edge. rx_at_done[8]
  // fires rx_valid with rx_at_done[7:0] during the completing cycle.
  task automatic apb_xfer(input bit u3, input bit wr, input logic [11:0] addr,
                          input logic [31:0] wdata, input logic [8:0] rx_at_done,
                          output logic [31:0] rdata, output logic err, output int acc);
    bit done = 1'b0;
    rdata = '0;
    err   = 1'b0;
    acc   = 0;
    set_apb(u3, 1'b1, 1'b0, wr, addr, wdata);
    @(posedge PCLK); #1;
    set_apb(u3, 1'b1, 1'b1, wr, addr, wdata);
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge PCLK);
      acc++;
      if ((u3 ? b_pready : pready) === 1'b1) begin
        rdata = u3 ? b_prdata : prdata;
        err   = u3 ? b_pslverr : pslverr;
        done  = 1'b1;
        if (rx_at_done[8]) begin
          rx_valid = 1'b1;
          rx_data  = rx_at_done[7:0];
        end
      end
      @(posedge PCLK); #1;
    end
    rx_valid = 1'b0;
    set_apb(u3, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    if (!done) begin
      n_errors++;
      $display("FAIL apb_timeout: addr %h got no PREADY expected PREADY within 16 cycles", addr);
    end
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge PCLK); #1;
    rx_valid = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[15];

  logic [31:0] rd;
  logic        er;
  int          acc;

  initial begin
    vecs[0]  = '{1'b0, 12'h004, 32'h0,        1'b0, 32'h0000_0002};  // STATUS after reset
    vecs[1]  = '{1'b0, 12'h000, 32'h0,        1'b0, 32'h0};          // CTRL after reset
    vecs[2]  = '{1'b1, 12'h010, 32'hFFFF_1234, 1'b0, 32'h0};         // BAUDIV write
    vecs[3]  = '{1'b0, 12'h010, 32'h0,        1'b0, 32'h0000_1234};  // BAUDIV readback
    vecs[4]  = '{1'b0, 12'h014, 32'h0,        1'b1, 32'h0};          // unmapped
    vecs[5]  = '{1'b0, 12'h006, 32'h0,        1'b1, 32'h0};          // misaligned read
    vecs[6]  = '{1'b1, 12'h00C, 32'h55,       1'b1, 32'h0};          // write RXDATA
    vecs[7]  = '{1'b0, 12'h008, 32'h0,        1'b1, 32'h0};          // read TXDATA
    vecs[8]  = '{1'b1, 12'h012, 32'hBEEF,     1'b1, 32'h0};          // misaligned write
    vecs[9]  = '{1'b0, 12'h010, 32'h0,        1'b0, 32'h0000_1234};  // BAUDIV untouched
    vecs[10] = '{1'b1, 12'h004, 32'hFFFF_FFFF, 1'b0, 32'h0};         // STATUS write is legal
    vecs[11] = '{1'b0, 12'h004, 32'h0,        1'b0, 32'h0000_0002};
    vecs[12] = '{1'b0, 12'h00C, 32'h0,        1'b0, 32'h0};          // RXDATA reset value
    vecs[13] = '{1'b1, 12'h000, 32'hFFFF_FFF0, 1'b0, 32'h0};         // upper bits ignored
    vecs[14] = '{1'b0, 12'h000, 32'h0,        1'b0, 32'h0};

    set_apb(1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    set_apb(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h0;
    b_tx_ready = 1'b0; b_rx_valid = 1'b0; b_rx_data = 8'h0;

    // ---- reset state ----
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_prdata", prdata, 32'h0);
    check("rst_pready", 32'(pready), 32'h0);
    check("rst_pslverr", 32'(pslverr), 32'h0);
    check("rst_tx", {23'h0, tx_valid, tx_data}, 32'h0);
    check("rst_ctrl", 32'(ctrl_o), 32'h0);
    check("rst_baud", 32'(baud_div_o), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // ---- table-driven register/decoder vectors ----
    for (int i = 0; i < 15; i++) begin
      apb_xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 9'h0, rd, er, acc);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_len", i), 32'(acc), 32'd3);
    end

    // ---- CTRL write with 2 wait states ----
    apb_xfer(1'b0, 1'b1, 12'h000, 32'h0000_000F, 9'h0, rd, er, acc);
    check("ctrl_wr_access_cycles", 32'(acc), 32'd3);
    check("ctrl_wr_err", 32'(er), 32'h0);
    check("ctrl_o_after", 32'(ctrl_o), 32'hF);
    check("irq_tx_empty", 32'(irq), 32'h1);
    apb_xfer(1'b0, 1'b1, 12'h000, 32'h3, 9'h0, rd, er, acc);

    // ---- TX FIFO fill, overflow, drain ----
    for (int i = 0; i < 8; i++) begin
      apb_xfer(1'b0, 1'b1, 12'h008, 32'h10 + i, 9'h0, rd, er, acc);
      check($sformatf("push%0d_err", i), 32'(er), 32'h0);
    end
    apb_xfer(1'b0, 1'b1, 12'h008, 32'h18, 9'h0, rd, er, acc);
    check("push_full_err", 32'(er), 32'h1);
    apb_xfer(1'b0, 1'b0, 12'h004, 32'h0, 9'h0, rd, er, acc);
    check("status_full", rd, 32'h0000_0801);
    @(negedge PCLK);
    check("tx_head_full", {23'h0, tx_valid, tx_data}, 32'h110);
    @(posedge PCLK); #1;
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge PCLK);
      check($sformatf("drain%0d", i), {23'h0, tx_valid, tx_data}, 32'h110 + i);
    end
    @(negedge PCLK);
    check("drain_done", {23'h0, tx_valid, tx_data}, 32'h0);
    tx_ready = 1'b0;
    @(posedge PCLK); #1;
    apb_xfer(1'b0, 1'b0, 12'h004, 32'h0, 9'h0, rd, er, acc);
    check("status_drained", rd, 32'h0000_0002);

    // ---- RX overrun ----
    rx_pulse(8'hA5);
    rx_pulse(8'h3C);
    apb_xfer(1'b0, 1'b0, 12'h004, 32'h0, 9'h0, rd, er, acc);
    check("status_overrun", rd, 32'h0000_000E);
    check("irq_overrun", 32'(irq), 32'h1);
    apb_xfer(1'b0, 1'b0, 12'h00C, 32'h0, 9'h0, rd, er, acc);
    check("rxdata_first", rd, 32'h0000_00A5);
    apb_xfer(1'b0, 1'b1, 12'h004, 32'h0000_0008, 9'h0, rd, er, acc);
    apb_xfer(1'b0, 1'b0, 12'h004, 32'h0, 9'h0, rd, er, acc);
    check("status_w1c", rd, 32'h0000_0002);
    check("irq_cleared", 32'(irq), 32'h0);

    // ---- RXDATA read coinciding with rx_valid ----
    rx_pulse(8'h11);
    apb_xfer(1'b0, 1'b0, 12'h00C, 32'h0, 9'h177, rd, er, acc);
    check("rx_same_cycle_old", rd, 32'h0000_0011);
    apb_xfer(1'b0, 1'b0, 12'h004, 32'h0, 9'h0, rd, er, acc);
    check("rx_same_cycle_status", rd, 32'h0000_0006);
    apb_xfer(1'b0, 1'b0, 12'h00C, 32'h0, 9'h0, rd, er, acc);
    check("rx_same_cycle_new", rd, 32'h0000_0077);
    apb_xfer(1'b0, 1'b1, 12'h000, 32'h1, 9'h0, rd, er, acc);
    rx_pulse(8'h99);
    apb_xfer(1'b0, 1'b0, 12'h004, 32'h0, 9'h0, rd, er, acc);
    check("rx_disabled", rd, 32'h0000_0002);

    // ---- aborted transfer on WAIT_STATES=3 instance ----
    set_apb(1'b1, 1'b1, 1'b0, 1'b1, 12'h000, 32'hF);
    @(posedge PCLK); #1;
    set_apb(1'b1, 1'b1, 1'b1, 1'b1, 12'h000, 32'hF);
    @(posedge PCLK); #1;
    set_apb(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    repeat (6) @(posedge PCLK);
    @(negedge PCLK);
    check("abort_ctrl", 32'(b_ctrl_o), 32'h0);
    check("abort_pready", 32'(b_pready), 32'h0);
    @(posedge PCLK); #1;
    apb_xfer(1'b1, 1'b1, 12'h000, 32'h5, 9'h0, rd, er, acc);
    check("post_abort_len", 32'(acc), 32'd4);
    check("post_abort_ctrl", 32'(b_ctrl_o), 32'h5);

    // ---- reset in the middle of a transfer ----
    apb_xfer(1'b0, 1'b1, 12'h000, 32'hF, 9'h0, rd, er, acc);
    rx_pulse(8'h42);
    apb_xfer(1'b0, 1'b1, 12'h008, 32'h5A, 9'h0, rd, er, acc);
    @(negedge PCLK);
    check("pre_rst_tx", {23'h0, tx_valid, tx_data}, 32'h15A);
    check("pre_rst_irq", 32'(irq), 32'h1);
    @(posedge PCLK); #1;
    set_apb(1'b0, 1'b1, 1'b0, 1'b0, 12'h010, 32'h0);
    @(posedge PCLK); #1;
    set_apb(1'b0, 1'b1, 1'b1, 1'b0, 12'h010, 32'h0);
    repeat (2) begin
      @(posedge PCLK); #1;
    end
    @(negedge PCLK);
    check("pre_rst_pready", 32'(pready), 32'h1);
    check("pre_rst_prdata", prdata, 32'h0000_1234);
    #1 PRESETn = 1'b0;
    #1;
    check("mid_rst_prdata", prdata, 32'h0);
    check("mid_rst_pready", 32'(pready), 32'h0);
    check("mid_rst_pslverr", 32'(pslverr), 32'h0);
    check("mid_rst_tx", {23'h0, tx_valid, tx_data}, 32'h0);
    check("mid_rst_ctrl", 32'(ctrl_o), 32'h0);
    check("mid_rst_baud", 32'(baud_div_o), 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    set_apb(1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    apb_xfer(1'b0, 1'b0, 12'h004, 32'h0, 9'h0, rd, er, acc);
    check("post_rst_status", rd, 32'h0000_0002);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
